des_undo_log_writer: RTL

//  Downstream consumer of the DES core undo-log port. Accepts {data,addr} undo entries,

---
 rtl/des_pkg.sv | 24 ++
 rtl/undo_entry_fifo.sv | 45 ++++
 rtl/des_undo_log_writer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared DES types and constants for the undo-log path between des_core and the L1 write port.
package des_pkg;

    localparam int UNDO_LOG_ADDR_W     = 32;
    localparam int UNDO_LOG_DATA_W     = 32;
    localparam int UNDO_LOG_SLOT_BYTES = 8;

    typedef logic [UNDO_LOG_ADDR_W-1:0] undo_log_addr_t;
    typedef logic [UNDO_LOG_DATA_W-1:0] undo_log_data_t;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_AW,
        WR_W0,
        WR_W1,
        WR_RESP
    } undo_wr_state_t;

    // Every entry is one 2-beat burst of 32-bit words.
    localparam logic [7:0] UNDO_AWLEN  = 8'd1;
    localparam logic [2:0] UNDO_AWSIZE = 3'b010;
    localparam logic [3:0] UNDO_WSTRB  = 4'hF;

endpackage

// File: rtl/undo_entry_fifo.sv
// Synchronous entry FIFO; head stays visible until popped, so it doubles as the retry buffer.
module undo_entry_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    // NOTE: storage is deliberately not reset; the pointers alone decide which slots are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/des_undo_log_writer.sv
// Buffers DES undo-log entries and writes each as a 2-beat AXI burst (addr word, data word)
// into the per-core undo-log region, counting committed entries per task.
module des_undo_log_writer
    import des_pkg::*;
#(
    parameter int UNDO_LOG_ADDR_WIDTH = UNDO_LOG_ADDR_W,
    parameter int UNDO_LOG_DATA_WIDTH = UNDO_LOG_DATA_W,
    parameter int FIFO_DEPTH          = 4,
    parameter int MAX_ENTRIES         = 64,
    localparam int ENTRY_W            = UNDO_LOG_ADDR_WIDTH + UNDO_LOG_DATA_WIDTH,
    localparam int CNT_W              = $clog2(MAX_ENTRIES) + 1
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               task_start,
    input  logic [31:0]        log_base,
    input  logic [ENTRY_W-1:0] undo_log_entry,
    input  logic               undo_log_entry_ap_vld,
    output logic               undo_log_entry_ap_rdy,
    output logic               m_axi_l1_V_AWVALID,
    input  logic               m_axi_l1_V_AWREADY,
    output logic [31:0]        m_axi_l1_V_AWADDR,
    output logic [7:0]         m_axi_l1_V_AWLEN,
    output logic [2:0]         m_axi_l1_V_AWSIZE,
    output logic               m_axi_l1_V_WVALID,
    input  logic               m_axi_l1_V_WREADY,
    output logic [31:0]        m_axi_l1_V_WDATA,
    output logic [3:0]         m_axi_l1_V_WSTRB,
    output logic               m_axi_l1_V_WLAST,
    input  logic               m_axi_l1_V_BVALID,
    output logic               m_axi_l1_V_BREADY,
    input  logic [1:0]         m_axi_l1_V_BRESP,
    input  logic               m_axi_l1_V_BID,
    output logic               drained,
    output logic [CNT_W-1:0]   entry_count,
    output logic               overflow,
    output logic               bresp_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ENTRIES);

    undo_wr_state_t state;
    undo_wr_state_t state_nxt;

    logic                           fifo_push;
    logic                           fifo_pop;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [ENTRY_W-1:0]             head;
    logic [UNDO_LOG_ADDR_WIDTH-1:0] head_addr;
    logic [UNDO_LOG_DATA_WIDTH-1:0] head_data;
    logic [31:0]                    log_base_q;
    logic                           at_max;
    logic                           drop_head;
    logic                           b_done;
    logic                           start_ok;
    logic                           unused_bid;

    assign unused_bid = m_axi_l1_V_BID;

    undo_entry_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .push      (fifo_push),
        .push_data (undo_log_entry),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_addr = head[UNDO_LOG_ADDR_WIDTH-1:0];
    assign head_data = head[ENTRY_W-1:UNDO_LOG_ADDR_WIDTH];

    assign undo_log_entry_ap_rdy = !fifo_full;
    assign fifo_push = undo_log_entry_ap_vld && !fifo_full;

    // A full task drops entries at the head instead of writing past its log region.
    assign at_max    = (entry_count >= MAX_CNT);
    assign drop_head = (state == WR_IDLE) && !fifo_empty && at_max;
    assign b_done    = (state == WR_RESP) && m_axi_l1_V_BVALID;
    assign fifo_pop  = drop_head || b_done;

    assign drained  = fifo_empty && (state == WR_IDLE);
    assign start_ok = task_start && drained;

    assign m_axi_l1_V_AWADDR = log_base_q + 32'(entry_count) * 32'(UNDO_LOG_SLOT_BYTES);
    assign m_axi_l1_V_AWLEN  = UNDO_AWLEN;
    assign m_axi_l1_V_AWSIZE = UNDO_AWSIZE;
    assign m_axi_l1_V_WSTRB  = UNDO_WSTRB;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= WR_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt          = state;
        m_axi_l1_V_AWVALID = 1'b0;
        m_axi_l1_V_WVALID  = 1'b0;
        m_axi_l1_V_WDATA   = '0;
        m_axi_l1_V_WLAST   = 1'b0;
        m_axi_l1_V_BREADY  = 1'b0;
        case (state)
            WR_IDLE: begin
                if (!fifo_empty && !at_max) state_nxt = WR_AW;
            end
            WR_AW: begin
                m_axi_l1_V_AWVALID = 1'b1;
                if (m_axi_l1_V_AWREADY) state_nxt = WR_W0;
            end
            WR_W0: begin
                m_axi_l1_V_WVALID = 1'b1;
                m_axi_l1_V_WDATA  = 32'(head_addr);
                if (m_axi_l1_V_WREADY) state_nxt = WR_W1;
            end
            WR_W1: begin
                m_axi_l1_V_WVALID = 1'b1;
                m_axi_l1_V_WDATA  = 32'(head_data);
                m_axi_l1_V_WLAST  = 1'b1;
                if (m_axi_l1_V_WREADY) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                m_axi_l1_V_BREADY = 1'b1;
                if (m_axi_l1_V_BVALID) state_nxt = WR_IDLE;
            end
            default: state_nxt = WR_IDLE;
        endcase
    end

    // task_start only takes effect when drained, so it never races a commit or a drop.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            log_base_q  <= '0;
            entry_count <= '0;
            overflow    <= 1'b0;
            bresp_err   <= 1'b0;
        end else if (start_ok) begin
            log_base_q  <= log_base;
            entry_count <= '0;
            overflow    <= 1'b0;
            bresp_err   <= 1'b0;
        end else begin
            if (drop_head) overflow <= 1'b1;
            if (b_done) begin
                if (!at_max)                  entry_count <= entry_count + CNT_W'(1);
                if (m_axi_l1_V_BRESP != 2'b00) bresp_err  <= 1'b1;
            end
        end
    end

endmodule
